load_store_unit: RTL and testbench
==================================

# load_store_unit

Byte-addressed load/store front end for the word-organised data memory. It accepts one byte, halfword or word request at a time from the core, converts the byte address to a word index, and drives the memory's `rd_en`/`wr_en`/`addr`/`data` port. Sub-word stores are done as read-modify-write. Load data is lane-extracted and sign/zero-extended before it is returned.

## Interface
- `ADDR_SHIFT`, 2: right shift from byte address to memory word index.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: block can accept a request.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned_i` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-justified.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and faults.
- `rsp_misaligned_o` out 1: the completed request was misaligned.
- `mem_rd_en_o` out 1: memory read enable.
- `mem_wr_en_o` out 1: memory write enable.
- `mem_addr_o` out 32: word index, `req_addr >> ADDR_SHIFT`.
- `mem_data_o` out 32: memory write data.
- `mem_data_i` in 32: memory read data. It is registered in the memory and valid in the cycle after `mem_rd_en_o`.
- `mem_ack_i` in 1: memory accepted the enable asserted in this cycle.

## Operation
- FSM states: IDLE, LD_RD, LD_CAP, RMW_RD, RMW_MRG, ST_WR, RESP.
- `req_ready_o` is 1 only in IDLE with `rst` low.
- A request is accepted when `req_valid_i && req_ready_o`. Address, size, we, unsigned and wdata are latched at that point.
- Transitions out of IDLE on accept:
  - Misaligned (see Configuration) → RESP.
  - Load → LD_RD.
  - Word store → ST_WR.
  - Byte/half store → RMW_RD.
- LD_RD and RMW_RD:
  - Drive `mem_rd_en_o`=1 and `mem_addr_o`.
  - Hold there while `mem_ack_i`=0.
  - On ack, advance to LD_CAP or RMW_MRG respectively.
- LD_CAP: sample `mem_data_i` and select the lane.
  - Lanes are little-endian: byte k is bits [8k+7:8k]. The byte lane is `addr[1:0]`; the half lane is `addr[1]`.
  - Extend per `req_unsigned_i` into the result register, then → RESP.
- RMW_MRG: sample `mem_data_i` and replace only the addressed byte/half lane with the low bits of the latched wdata, then → ST_WR.
- ST_WR:
  - Drive `mem_wr_en_o`=1 with the word or merged data on `mem_data_o`.
  - Hold while `mem_ack_i`=0, then → RESP.
- RESP: `rsp_valid_o`=1 for exactly one cycle, then → IDLE.
- `mem_rd_en_o` and `mem_wr_en_o` are never both 1. Both are 0 outside LD_RD/RMW_RD/ST_WR.
- Reset values: state IDLE; every output 0, including `req_ready_o` while `rst`=1; `mem_addr_o`/`mem_data_o` = 0.
- Reset mid-operation:
  - The transaction is abandoned; no enable is asserted in the cycle after the reset edge.
  - An RMW interrupted before ST_WR leaves memory unmodified.
  - No `rsp_valid_o` is issued for the abandoned request.

## Timing
Request accepted at edge T (IDLE). Aligned load:
- T+1: `mem_rd_en_o`.
- T+2: capture.
- T+3: `rsp_valid_o`.
- T+4: `req_ready_o`=1 again.

Word store:
- T+1: `mem_wr_en_o`.
- T+2: `rsp_valid_o`.

Sub-word store:
- T+1: read.
- T+2: merge.
- T+3: write.
- T+4: `rsp_valid_o`.

Other timing:
- Misaligned request: `rsp_valid_o` at T+1, with no memory enable.
- Each cycle `mem_ack_i` stays low adds one cycle of latency.
- Back-to-back throughput is one request per (latency + 1) cycles; there is no overlap.

## Configuration
`LSU_MISALIGN_TRAP_EN` is defined:
- Halfwords with `addr[0]`=1 and words with `addr[1:0]`≠0 complete without any memory access.
- They return `rsp_misaligned_o`=1 and `rsp_rdata_o`=0.

`LSU_MISALIGN_TRAP_EN` is undefined:
- Offending low address bits are forced to 0: halfword `addr[0]` is cleared, and `addr[1:0]` is cleared for words.
- The access proceeds normally and `rsp_misaligned_o` is tied 0.

## Test plan
- Word store of 0xDEADBEEF to 0x40, then word load from 0x40 → `mem_addr_o`=0x10 on both accesses; load returns 0xDEADBEEF at T+3; store response at T+2.
- Memory word 0x10 = 0x11223344; byte store 0xAA to 0x42 → one read, then a write of 0x11AA3344; `rsp_valid_o` at T+4.
- Memory word = 0x80FF7F01:
  - Signed byte load at +3 → 0xFFFFFF80.
  - Unsigned byte load at +3 → 0x00000080.
  - Signed half load at +0 → 0x00007F01.
  - Signed half load at +2 → 0xFFFF80FF.
- With `LSU_MISALIGN_TRAP_EN`: word load at 0x41 → `rsp_misaligned_o`=1 and rdata 0 at T+1, with no enable. Without it: the same load reads word 0x10.
- `mem_ack_i` held low for 3 cycles during LD_RD → `mem_rd_en_o` stays high for 4 cycles; response is 3 cycles late with correct data.
- `rst` pulsed in RMW_MRG → no `mem_wr_en_o`, no response, memory unchanged; `req_ready_o`=1 the cycle after `rst` deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end with sub-word read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses complete with a flag instead of being aligned).
`default_nettype none

module load_store_unit #(
  parameter int unsigned ADDR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_misaligned_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_RD   = 3'd1,
    S_LD_CAP  = 3'd2,
    S_RMW_RD  = 3'd3,
    S_RMW_MRG = 3'd4,
    S_ST_WR   = 3'd5,
    S_RESP    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        misal_q, misal_d;
  // Holds store data until the write, then the merged word; holds the load result for loads.
  logic [31:0] data_q, data_d;

  logic [1:0]  w_size;
  logic        w_misal;
  logic [31:0] w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  assign w_size = (req_size_i == 2'b11) ? 2'b10 : req_size_i;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misal = ((w_size == 2'b01) && req_addr_i[0]) ||
                   ((w_size == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign w_addr  = req_addr_i;
`else
  assign w_misal = 1'b0;
  always_comb begin
    w_addr = req_addr_i;
    if (w_size == 2'b01) w_addr[0] = 1'b0;
    else if (w_size == 2'b10) w_addr[1:0] = 2'b00;
  end
`endif

  assign w_byte = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
  assign w_half = addr_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];

  always_comb begin
    w_load_ext = mem_data_i;
    case (size_q)
      2'b00:   w_load_ext = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = mem_data_i;
    endcase
  end

  always_comb begin
    w_merged = mem_data_i;
    if (size_q == 2'b00) w_merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else                 w_merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    misal_d = misal_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = w_addr;
          size_d  = w_size;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          misal_d = w_misal;
          data_d  = w_misal ? 32'd0 : req_wdata_i;
          if (w_misal)              state_d = S_RESP;
          else if (!req_we_i)       state_d = S_LD_RD;
          else if (w_size == 2'b10) state_d = S_ST_WR;
          else                      state_d = S_RMW_RD;
        end
      end
      S_LD_RD:   if (mem_ack_i) state_d = S_LD_CAP;
      S_LD_CAP: begin
        data_d  = w_load_ext;
        state_d = S_RESP;
      end
      S_RMW_RD:  if (mem_ack_i) state_d = S_RMW_MRG;
      S_RMW_MRG: begin
        data_d  = w_merged;
        state_d = S_ST_WR;
      end
      S_ST_WR:   if (mem_ack_i) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      misal_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      misal_q <= misal_d;
      data_q  <= data_d;
    end
  end

  // Outputs are gated by rst so everything reads 0 during a reset cycle, even mid-transaction.
  assign req_ready_o      = (state_q == S_IDLE) && !rst;
  assign mem_rd_en_o      = ((state_q == S_LD_RD) || (state_q == S_RMW_RD)) && !rst;
  assign mem_wr_en_o      = (state_q == S_ST_WR) && !rst;
  assign mem_addr_o       = (mem_rd_en_o || mem_wr_en_o) ? (addr_q >> ADDR_SHIFT) : 32'd0;
  assign mem_data_o       = mem_wr_en_o ? data_q : 32'd0;
  assign rsp_valid_o      = (state_q == S_RESP) && !rst;
  assign rsp_rdata_o      = (rsp_valid_o && !we_q) ? data_q : 32'd0;
  assign rsp_misaligned_o = rsp_valid_o && misal_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests against a byte-array reference memory.
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, rsp_misaligned_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_rd_en_o, mem_wr_en_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_SHIFT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_misaligned_o(rsp_misaligned_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'h9E3779B9 * (i + 1);
    return v ^ 32'h5A5A0000;
  endfunction

  // Memory: 32 words, registered read data, acts only on acked enables.
  logic [31:0] mem [32];
  logic [31:0] mem_q;
  logic        mem_inited = 1'b0;
  assign mem_data_i = mem_q;

  always @(posedge clk) begin
    if (rst) begin
      if (!mem_inited) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        mem_inited <= 1'b1;
      end
      mem_q <= 32'd0;
    end else begin
      if (mem_rd_en_o && mem_ack_i) mem_q <= mem[mem_addr_o[4:0]];
      if (mem_wr_en_o && mem_ack_i) mem[mem_addr_o[4:0]] <= mem_data_o;
    end
  end

  logic [7:0] ref_b [128];

  // Bus monitor counters (cumulative; transactions use deltas).
  int rd_acks = 0, wr_acks = 0, stalls = 0, rd_cycles = 0, both_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  always @(negedge clk) begin
    if (mem_rd_en_o && mem_wr_en_o) both_cnt++;
    if (mem_rd_en_o) rd_cycles++;
    if ((mem_rd_en_o || mem_wr_en_o) && !mem_ack_i) stalls++;
    if (mem_rd_en_o && mem_ack_i) begin rd_acks++; last_addr = mem_addr_o; end
    if (mem_wr_en_o && mem_ack_i) begin wr_acks++; last_addr = mem_addr_o; end
    if (rsp_valid_o) rsp_cnt++;
  end

  bit rand_ack = 1'b0;
  int hold_low = 0;
  initial begin
    mem_ack_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0 && (mem_rd_en_o || mem_wr_en_o)) begin
        mem_ack_i = 1'b0;
        hold_low--;
      end else begin
        mem_ack_i = rand_ack ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Reference model: byte-level memory, plain arithmetic on lanes.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] e_rdata, output logic e_mis, output int e_lat,
                       output int e_rd, output int e_wr, output int e_ea);
    int nb, off, ea;
    longint v;
    nb = (size == 2'd3) ? 4 : (1 << size);
    off = int'(addr) % nb;
    e_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e_mis = (off != 0);
`endif
    ea = int'(addr) - off;
    e_ea = ea;
    e_rdata = 32'd0;
    if (e_mis) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!we) begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v + (longint'(ref_b[ea + k]) << (8 * k));
      if (!uns && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
      e_rdata = v[31:0];
      e_lat = 3; e_rd = 1; e_wr = 0;
    end else begin
      for (int k = 0; k < nb; k++) ref_b[ea + k] = wdata[8 * k +: 8];
      e_lat = (nb == 4) ? 2 : 4; e_rd = (nb == 4) ? 0 : 1; e_wr = 1;
    end
  endtask

  logic [31:0] last_rdata;
  int last_lat, last_stalls, last_rdcyc;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] e_rdata, got_rdata, ref_word;
    logic e_mis, got_mis;
    int e_lat, e_rd, e_wr, e_ea, n, s0, r0, w0, b0, c0;
    bit seen;
    model(we, size, uns, addr, wdata, e_rdata, e_mis, e_lat, e_rd, e_wr, e_ea);
    @(posedge clk);
    #1;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; req_wdata_i = $urandom; req_addr_i = $urandom;
    s0 = stalls; r0 = rd_acks; w0 = wr_acks; b0 = both_cnt; c0 = rd_cycles;
    seen = 1'b0; n = 0; got_rdata = 32'd0; got_mis = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (rsp_valid_o) begin seen = 1'b1; got_rdata = rsp_rdata_o; got_mis = rsp_misaligned_o; end
    end
    check("rsp_timeout", 32'(seen), 32'd1);
    if (!seen) return;
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
    check("ready_after_rsp", 32'(req_ready_o), 32'd1);
    #1;
    last_rdata = got_rdata; last_lat = n; last_stalls = stalls - s0; last_rdcyc = rd_cycles - c0;
    check("rdata", got_rdata, e_rdata);
    check("misaligned", 32'(got_mis), 32'(e_mis));
    check("latency", 32'(n), 32'(e_lat + last_stalls));
    check("rd_accesses", 32'(rd_acks - r0), 32'(e_rd));
    check("wr_accesses", 32'(wr_acks - w0), 32'(e_wr));
    check("rd_wr_overlap", 32'(both_cnt - b0), 32'd0);
    if (!e_mis) begin
      check("mem_addr", last_addr, 32'(e_ea >> 2));
      ref_word = {ref_b[(e_ea & ~3) + 3], ref_b[(e_ea & ~3) + 2],
                  ref_b[(e_ea & ~3) + 1], ref_b[e_ea & ~3]};
      check("mem_word", mem[e_ea >> 2], ref_word);
    end
  endtask

  initial begin
    int r0, w0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_b[4 * i + k] = w[8 * k +: 8];
    end
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(req_ready_o), 32'd0);
    check("reset_outputs", {26'd0, rsp_valid_o, rsp_misaligned_o, mem_rd_en_o, mem_wr_en_o,
                            |mem_addr_o, |mem_data_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready_o), 32'd1);

    // Word store then word load at 0x40.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    check("plan_st_word_lat", 32'(last_lat), 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("plan_ld_word", last_rdata, 32'hDEADBEEF);
    check("plan_ld_word_lat", 32'(last_lat), 32'd3);

    // Byte store read-modify-write.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h42, 32'h000000AA);
    check("plan_rmw_word", mem[16], 32'h11AA3344);
    check("plan_rmw_lat", 32'(last_lat), 32'd4);

    // Lane extraction and extension.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h80FF7F01);
    do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
    check("plan_lb_signed", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
    check("plan_lb_unsigned", last_rdata, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
    check("plan_lh_lo", last_rdata, 32'h00007F01);
    do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
    check("plan_lh_hi", last_rdata, 32'hFFFF80FF);

    // Misaligned word load.
    do_req(1'b0, 2'b10, 1'b0, 32'h41, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("plan_misal_lat", 32'(last_lat), 32'd1);
`else
    check("plan_misal_data", last_rdata, 32'h80FF7F01);
`endif

    // Ack held low for three cycles during the read.
    hold_low = 3;
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("plan_stall_cnt", 32'(last_stalls), 32'd3);
    check("plan_stall_rd_cycles", 32'(last_rdcyc), 32'd4);
    check("plan_stall_lat", 32'(last_lat), 32'd6);
    check("plan_stall_data", last_rdata, 32'h80FF7F01);
    hold_low = 0;

    // Reset during the merge state of a byte store.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344);
    r0 = rsp_cnt; w0 = wr_acks;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00; req_addr_i = 32'h41;
    req_wdata_i = 32'h00000055;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready_o), 32'd0);
    check("rst_mid_wr", 32'(mem_wr_en_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", 32'(req_ready_o), 32'd1);
    repeat (6) @(negedge clk);
    check("rst_mid_no_write", 32'(wr_acks - w0), 32'd0);
    check("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check("rst_mid_mem", mem[16], 32'h11223344);

    // Randomized traffic with random ack stalls.
    rand_ack = 1'b1;
    for (int t = 0; t < 200; t++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 127)), $urandom);
    end
    rand_ack = 1'b0;

    for (int i = 0; i < 32; i++)
      check("final_mem", mem[i], {ref_b[4 * i + 3], ref_b[4 * i + 2], ref_b[4 * i + 1], ref_b[4 * i]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
